// File: rtl/iter_alu_if.sv
// Request/result bundle of the iterative ALU.
// The requester drives start, op and the operands; the ALU returns the
// registered result, its status flags and the busy/done handshake.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output start, op, in_a, in_b,
    input  result, zero, neg, err, busy, done
  );

  modport slave (
    input  start, op, in_a, in_b,
    output result, zero, neg, err, busy, done
  );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: logic/add/compare ops complete in one cycle, while
// multiply (shift-add) and unsigned divide/remainder (restoring division)
// take one bit per cycle over WIDTH cycles. The result and the zero/neg/err
// flags are registered together and held until the next completion.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  iter_alu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             neg_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] quick_res;
  logic             quick_err;
  logic             quick_iter;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             qbit;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  logic [WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0] iter_a;
  logic [WIDTH-1:0] iter_b;
  logic [WIDTH-1:0] iter_res;

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Decode the incoming request: single-cycle result, error, or iterative op.
  always_comb begin
    quick_res  = '0;
    quick_err  = 1'b0;
    quick_iter = 1'b0;
    case (bus.op)
      OP_ADD:  quick_res = bus.in_a + bus.in_b;
      OP_SUB:  quick_res = bus.in_a - bus.in_b;
      OP_AND:  quick_res = bus.in_a & bus.in_b;
      OP_OR:   quick_res = bus.in_a | bus.in_b;
      OP_XOR:  quick_res = bus.in_a ^ bus.in_b;
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
      OP_MUL:  quick_iter = 1'b1;
      OP_DIVU: begin
        if (bus.in_b == '0) begin
          quick_res = '1;
          quick_err = 1'b1;
        end else begin
          quick_iter = 1'b1;
        end
      end
      OP_REMU: begin
        if (bus.in_b == '0) begin
          quick_res = bus.in_a;
          quick_err = 1'b1;
        end else begin
          quick_iter = 1'b1;
        end
      end
      default: quick_err = 1'b1;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    mul_acc = acc_q + (b_q[0] ? a_q : '0);
    mul_a   = a_q << 1;
    mul_b   = b_q >> 1;
  end

  // One restoring-division step: bring in the next dividend bit and try to subtract the divisor.
  always_comb begin
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    qbit      = ~rem_diff[WIDTH];
    div_rem   = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    div_quo   = {a_q[WIDTH-2:0], qbit};
  end

  // Select the next iteration state and the final value for the latched operation.
  always_comb begin
    iter_acc = div_rem;
    iter_a   = div_quo;
    iter_b   = b_q;
    iter_res = div_quo;
    if (op_q == OP_MUL) begin
      iter_acc = mul_acc;
      iter_a   = mul_a;
      iter_b   = mul_b;
      iter_res = mul_acc;
    end else if (op_q == OP_REMU) begin
      iter_res = div_rem;
    end
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            acc_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (quick_iter) begin
              state <= CALC;
            end else begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= quick_res;
              zero_q   <= (quick_res == '0);
              neg_q    <= quick_res[WIDTH-1];
              err_q    <= quick_err;
            end
          end
        end
        CALC: begin
          acc_q <= iter_acc;
          a_q   <= iter_a;
          b_q   <= iter_b;
          if (cnt == LAST_ITER) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= iter_res;
            zero_q   <= (iter_res == '0);
            neg_q    <= iter_res[WIDTH-1];
            err_q    <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: expected results are pushed when a request
// is driven and popped when the unit signals done.
module tb_iter_alu;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t exp_q [$];
  exp_t exp8_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  iter_alu_if #(.WIDTH(32)) bus ();
  iter_alu_if #(.WIDTH(8))  bus8 ();

  iter_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  iter_alu #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      OP_ADD:  e.res = a + b;
      OP_SUB:  e.res = a - b;
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_MUL: begin
        e.res = a * b;
        e.lat = 33;
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          e.res = 32'hFFFF_FFFF;
          e.err = 1'b1;
        end else begin
          e.res = a / b;
          e.lat = 33;
        end
      end
      OP_REMU: begin
        if (b == 32'd0) begin
          e.res = a;
          e.err = 1'b1;
        end else begin
          e.res = a % b;
          e.lat = 33;
        end
      end
      default: begin
        e.res = 32'd0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    e.neg  = e.res[31];
    return e;
  endfunction

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_wait: busy got %b, expected 0", bus.busy);
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.in_a  = a;
    bus.in_b  = b;
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.in_a  = ~a;
    bus.in_b  = a ^ b ^ 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: done got %b after %0d cycles, expected 1", bus.done, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.op = 4'h0;  bus.in_a = '0;  bus.in_b = '0;
    bus8.start = 1'b0; bus8.op = 4'h0; bus8.in_a = '0; bus8.in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got %h, expected 0", bus.result);
    end
    vectors++;
    if ({bus.zero, bus.neg, bus.err, bus.busy, bus.done} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000",
               {bus.zero, bus.neg, bus.err, bus.busy, bus.done});
    end
    vectors++;
    if ({bus8.result, bus8.zero, bus8.neg, bus8.err, bus8.busy, bus8.done} !== 13'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_w8: got %h, expected 0",
               {bus8.result, bus8.zero, bus8.neg, bus8.err, bus8.busy, bus8.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops [8] = '{OP_ADD, OP_SLT, OP_SLTU, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADD};
    logic [31:0] as  [8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                             32'hF0F0_FF00, 32'h1234_0000, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
    logic [31:0] bs  [8] = '{32'd1, 32'd1, 32'd1, 32'd5,
                             32'h0FF0_F0F0, 32'h0000_5678, 32'hFFFF_0000, 32'd1};
    exp_t e;
    int   lat;
    bit   bok;
    for (int i = 0; i < 8; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_done(lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (bus.result !== e.res) begin
        miscompares++;
        $display("[TB] FAIL single%0d_op%0h result: got %h, expected %h", i, ops[i], bus.result, e.res);
      end
      vectors++;
      if ({bus.zero, bus.neg, bus.err} !== {e.zero, e.neg, e.err}) begin
        miscompares++;
        $display("[TB] FAIL single%0d_op%0h zne: got %b, expected %b", i, ops[i],
                 {bus.zero, bus.neg, bus.err}, {e.zero, e.neg, e.err});
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("[TB] FAIL single%0d_op%0h latency: got %0d, expected %0d", i, ops[i], lat, e.lat);
      end
    end
  endtask

  task automatic test_iterative();
    logic [3:0]  ops [7] = '{OP_MUL, OP_MUL, OP_DIVU, OP_REMU, OP_MUL, OP_DIVU, OP_REMU};
    logic [31:0] as  [7];
    logic [31:0] bs  [7];
    exp_t e;
    int   lat;
    bit   bok;
    as = '{32'd7, 32'hFFFF_FFFD, 32'd100, 32'd100, $urandom, $urandom, 32'hFFFF_FFFF};
    bs = '{32'd6, 32'd5, 32'd7, 32'd7, $urandom, $urandom_range(1, 5000), 32'h8000_0001};
    for (int i = 0; i < 7; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_done(lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (bus.result !== e.res) begin
        miscompares++;
        $display("[TB] FAIL iter%0d_op%0h result: got %h, expected %h", i, ops[i], bus.result, e.res);
      end
      vectors++;
      if ({bus.zero, bus.neg, bus.err} !== {e.zero, e.neg, e.err}) begin
        miscompares++;
        $display("[TB] FAIL iter%0d_op%0h zne: got %b, expected %b", i, ops[i],
                 {bus.zero, bus.neg, bus.err}, {e.zero, e.neg, e.err});
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("[TB] FAIL iter%0d_op%0h latency: got %0d, expected %0d", i, ops[i], lat, e.lat);
      end
      vectors++;
      if (bok !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL iter%0d_op%0h busy: got dropped, expected held", i, ops[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops [5] = '{OP_DIVU, OP_REMU, 4'b1111, 4'b0111, 4'b1011};
    logic [31:0] as  [5] = '{32'd9, 32'd9, 32'h1234_5678, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'd1, 32'd4, 32'd2};
    exp_t e;
    int   lat;
    bit   bok;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_done(lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if (bus.result !== e.res) begin
        miscompares++;
        $display("[TB] FAIL err%0d_op%0h result: got %h, expected %h", i, ops[i], bus.result, e.res);
      end
      vectors++;
      if ({bus.zero, bus.neg, bus.err} !== {e.zero, e.neg, e.err}) begin
        miscompares++;
        $display("[TB] FAIL err%0d_op%0h zne: got %b, expected %b", i, ops[i],
                 {bus.zero, bus.neg, bus.err}, {e.zero, e.neg, e.err});
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("[TB] FAIL err%0d_op%0h latency: got %0d, expected %0d", i, ops[i], lat, e.lat);
      end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   lat;
    bit   bok;
    drive_op(OP_MUL, 32'd7, 32'd6);
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.in_a  = 32'd1000;
    bus.in_b  = 32'd2000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bok);
    lat = lat + 6;
    e = exp_q.pop_front();
    vectors++;
    if (bus.result !== e.res) begin
      miscompares++;
      $display("[TB] FAIL ignore_calc result: got %h, expected %h", bus.result, e.res);
    end
    vectors++;
    if (lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL ignore_calc latency: got %0d, expected %0d", lat, e.lat);
    end
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.in_a  = 32'd3;
    bus.in_b  = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL ignore_done busy_done: got %b, expected 00", {bus.busy, bus.done});
    end
    vectors++;
    if (bus.result !== e.res) begin
      miscompares++;
      $display("[TB] FAIL ignore_done held: got %h, expected %h", bus.result, e.res);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{OP_ADD, OP_DIVU, OP_XOR, OP_MUL};
    logic [31:0] as  [4] = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0001};
    logic [31:0] bs  [4] = '{32'd1, 32'd3, 32'hFFFF_FFFF, 32'h0000_FFFF};
    exp_t e;
    int   lat;
    bit   bok;
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_done(lat, bok);
      e = exp_q.pop_front();
      vectors++;
      if ({bus.result, bus.zero, bus.neg, bus.err} !== {e.res, e.zero, e.neg, e.err}) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d_op%0h result_zne: got %h/%b, expected %h/%b", i, ops[i],
                 bus.result, {bus.zero, bus.neg, bus.err}, e.res, {e.zero, e.neg, e.err});
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d_op%0h latency: got %0d, expected %0d", i, ops[i], lat, e.lat);
      end
      @(posedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d_pulse busy_done: got %b, expected 00", i, {bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    exp_t e;
    int   lat;
    bit   bok;
    bit   seen_done;
    drive_op(OP_MUL, 32'd123, 32'd456);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if ({bus.result, bus.zero, bus.neg, bus.err, bus.busy, bus.done} !== 37'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %h/%b, expected 0/00000", bus.result,
               {bus.zero, bus.neg, bus.err, bus.busy, bus.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done: got pulse, expected none");
    end
    drive_op(OP_ADD, 32'h10, 32'h20);
    wait_done(lat, bok);
    e = exp_q.pop_front();
    vectors++;
    if ({bus.result, bus.err} !== {e.res, e.err}) begin
      miscompares++;
      $display("[TB] FAIL midreset_next: got %h/%b, expected %h/%b", bus.result, bus.err, e.res, e.err);
    end
    vectors++;
    if (lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL midreset_next latency: got %0d, expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_width8();
    logic [3:0] ops [3] = '{OP_MUL, OP_DIVU, OP_REMU};
    logic [7:0] as  [3] = '{8'd15, 8'd200, 8'd200};
    logic [7:0] bs  [3] = '{8'd17, 8'd7, 8'd7};
    logic [15:0] prod;
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      prod = as[i] * bs[i];
      e.res = 32'd0;
      if (ops[i] == OP_MUL)       e.res[7:0] = prod[7:0];
      else if (ops[i] == OP_DIVU) e.res[7:0] = as[i] / bs[i];
      else                        e.res[7:0] = as[i] % bs[i];
      e.zero = (e.res[7:0] == 8'd0);
      e.neg  = e.res[7];
      e.err  = 1'b0;
      e.lat  = 9;
      bus8.start = 1'b1;
      bus8.op    = ops[i];
      bus8.in_a  = as[i];
      bus8.in_b  = bs[i];
      exp8_q.push_back(e);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.in_a  = ~as[i];
      bus8.in_b  = 8'hA5;
      lat = 1;
      while (bus8.done !== 1'b1 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      e = exp8_q.pop_front();
      vectors++;
      if ({bus8.result, bus8.zero, bus8.neg, bus8.err} !== {e.res[7:0], e.zero, e.neg, e.err}) begin
        miscompares++;
        $display("[TB] FAIL w8_%0d_op%0h result_zne: got %h/%b, expected %h/%b", i, ops[i],
                 bus8.result, {bus8.zero, bus8.neg, bus8.err}, e.res[7:0], {e.zero, e.neg, e.err});
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("[TB] FAIL w8_%0d_op%0h latency: got %0d, expected %0d", i, ops[i], lat, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
    test_errors();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_calc();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
